// File: rtl/guess_entry.sv
// Mastermind player-input front end: collects four validated colour codes from
// a debounced-by-edge enter button, assembles the guess and hands it to the grader.
module guess_entry #(
  parameter int unsigned MIN_COLOR    = 1,
  parameter int unsigned MAX_COLOR    = 6,
  parameter int unsigned GRADE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_game,
  input  logic [2:0]  color_in,
  input  logic        enter,
  input  logic        game_over,
  output logic [11:0] guess,
  output logic        grade_it,
  output logic [2:0]  slot_count,
  output logic        entry_error,
  output logic        busy
);

  localparam int unsigned CW = 3;
  localparam int unsigned GW = 12;
  localparam int unsigned SW = 3;
  localparam int unsigned TW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTER = 2'd1,
    S_GRADE = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] guess_q, guess_d;
  logic [SW-1:0] slot_count_q, slot_count_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          grade_it_q, grade_it_d;
  logic          entry_error_q, entry_error_d;
  logic          busy_q, busy_d;
  logic [2:0]    sync_q, sync_d;
  logic          press;
  logic          color_ok;
  logic [GW-1:0] guess_wr;

  // sync_q[0..1] is the metastability chain, sync_q[2] the edge-detect history
  assign sync_d   = {sync_q[1:0], enter};
  assign press    = sync_q[1] & ~sync_q[2];
  assign color_ok = (color_in >= CW'(MIN_COLOR)) && (color_in <= CW'(MAX_COLOR));

  // First colour of a round also wipes the rest of the previous guess
  always_comb begin
    guess_wr = guess_q;
    case (slot_count_q[1:0])
      2'd0:    guess_wr = {color_in, 9'd0};
      2'd1:    guess_wr = {guess_q[11:9], color_in, guess_q[5:0]};
      2'd2:    guess_wr = {guess_q[11:6], color_in, guess_q[2:0]};
      default: guess_wr = {guess_q[11:3], color_in};
    endcase
  end

  always_comb begin
    state_d       = state_q;
    guess_d       = guess_q;
    slot_count_d  = slot_count_q;
    cnt_d         = cnt_q;
    entry_error_d = 1'b0;

    if (start_game) begin
      state_d      = S_ENTER;
      guess_d      = '0;
      slot_count_d = '0;
      cnt_d        = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
        end
        S_ENTER: begin
          if (press) begin
            if (color_ok) begin
              guess_d      = guess_wr;
              slot_count_d = slot_count_q + SW'(1);
              if (slot_count_q == SW'(3)) begin
                state_d = S_GRADE;
                cnt_d   = TW'(GRADE_CYCLES - 1);
              end
            end else begin
              entry_error_d = 1'b1;
            end
          end
        end
        S_GRADE: begin
          if (cnt_q == '0) begin
            state_d = S_HOLD;
            cnt_d   = TW'(HOLD_CYCLES - 1);
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
        default: begin
          // Last HOLD cycle decides between another round and game end
          if (cnt_q == '0) begin
            state_d      = game_over ? S_IDLE : S_ENTER;
            slot_count_d = '0;
          end else begin
            cnt_d = cnt_q - TW'(1);
          end
        end
      endcase
    end

    grade_it_d = (state_d == S_GRADE);
    busy_d     = (state_d == S_GRADE) || (state_d == S_HOLD);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      guess_q       <= '0;
      slot_count_q  <= '0;
      cnt_q         <= '0;
      grade_it_q    <= 1'b0;
      entry_error_q <= 1'b0;
      busy_q        <= 1'b0;
      sync_q        <= '0;
    end else begin
      state_q       <= state_d;
      guess_q       <= guess_d;
      slot_count_q  <= slot_count_d;
      cnt_q         <= cnt_d;
      grade_it_q    <= grade_it_d;
      entry_error_q <= entry_error_d;
      busy_q        <= busy_d;
      sync_q        <= sync_d;
    end
  end

  assign guess       = guess_q;
  assign grade_it    = grade_it_q;
  assign slot_count  = slot_count_q;
  assign entry_error = entry_error_q;
  assign busy        = busy_q;

endmodule
